// File: rtl/accum_param_pkg.sv
// accum_pkg: shared definitions for the accum_param accumulator slice.
//   accum_mode_t : operation select carried on the bus mode field
//     MODE_ADD  2'b00  sum + din
//     MODE_SUB  2'b01  sum - din
//     MODE_LOAD 2'b10  sum = min(din, LIMIT)
//     MODE_CLR  2'b11  sum = INIT, sticky flags cleared
package accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_LOAD = 2'b10,
    MODE_CLR  = 2'b11
  } accum_mode_t;

endpackage

// File: rtl/accum_param_if.sv
// accum_param_if: operation/result bundle of the accumulator.
//   en      master->slave  operation enable (0 = hold)
//   mode    master->slave  accum_mode_t operation select
//   din     master->slave  WIDTH-bit operand
//   show    master->slave  snapshot capture request
//   acc     slave->master  snapshot of the running sum
//   acc_vld slave->master  1-cycle pulse after each capture
//   ovf     slave->master  sticky add overflow
//   unf     slave->master  sticky sub underflow
//   zero    slave->master  registered running sum == 0
interface accum_param_if #(
  parameter int unsigned WIDTH = 6
);
  import accum_pkg::*;

  logic             en;
  accum_mode_t      mode;
  logic [WIDTH-1:0] din;
  logic             show;
  logic [WIDTH-1:0] acc;
  logic             acc_vld;
  logic             ovf;
  logic             unf;
  logic             zero;

  modport master (
    output en, mode, din, show,
    input  acc, acc_vld, ovf, unf, zero
  );

  modport slave (
    input  en, mode, din, show,
    output acc, acc_vld, ovf, unf, zero
  );

endinterface

// File: rtl/accum_param_alu.sv
// accum_alu: combinational next-sum computation for accum_param.
//   i_sum      current running sum (0..LIMIT)
//   i_din      operand; values above LIMIT are clamped to LIMIT
//   i_mode     accum_mode_t operation
//   o_next_sum resulting sum
//   o_ovf_evt  add went past LIMIT
//   o_unf_evt  sub went below 0
// Build option ACCUM_SATURATE_EN: clamp at LIMIT/0 instead of wrapping
// modulo (LIMIT+1). Events are flagged in both builds.
module accum_alu
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LIMIT = 2**WIDTH - 1,
  parameter int unsigned INIT  = 0
) (
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_din,
  input  accum_mode_t      i_mode,
  output logic [WIDTH-1:0] o_next_sum,
  output logic             o_ovf_evt,
  output logic             o_unf_evt
);

  localparam logic [WIDTH:0]   LIM_X  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_W  = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic [WIDTH:0] w_din_x;
  logic [WIDTH:0] w_sum_x;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub_wrap;

  always_comb begin
    w_din_x = {1'b0, i_din};
    if (w_din_x > LIM_X) begin
      w_din_x = LIM_X;
    end
    w_sum_x = {1'b0, i_sum};
    w_add   = w_sum_x + w_din_x;
    // sum + (LIMIT+1) - din stays within WIDTH+1 bits since sum <= LIMIT
    w_sub_wrap = w_sum_x + LIM_X + 1'b1 - w_din_x;

    o_next_sum = i_sum;
    o_ovf_evt  = 1'b0;
    o_unf_evt  = 1'b0;

    unique case (i_mode)
      MODE_ADD: begin
        if (w_add > LIM_X) begin
          o_ovf_evt = 1'b1;
`ifdef ACCUM_SATURATE_EN
          o_next_sum = LIM_W;
`else
          o_next_sum = WIDTH'(w_add - LIM_X - 1'b1);
`endif
        end else begin
          o_next_sum = WIDTH'(w_add);
        end
      end
      MODE_SUB: begin
        if (w_din_x > w_sum_x) begin
          o_unf_evt = 1'b1;
`ifdef ACCUM_SATURATE_EN
          o_next_sum = '0;
`else
          o_next_sum = WIDTH'(w_sub_wrap);
`endif
        end else begin
          o_next_sum = WIDTH'(w_sum_x - w_din_x);
        end
      end
      MODE_LOAD: o_next_sum = WIDTH'(w_din_x);
      MODE_CLR:  o_next_sum = INIT_W;
      default:   o_next_sum = i_sum;
    endcase
  end

  // LIM_W is only referenced by the saturating build
  logic w_unused;
  assign w_unused = ^LIM_W;

endmodule

// File: rtl/accum_param.sv
// accum_param: parametrised up/down accumulator with sticky flags and a
// registered snapshot output.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  accum_param_if.slave: en/mode/din/show in, acc/acc_vld/ovf/unf/zero out
// Build option ACCUM_SATURATE_EN (in accum_alu): saturating add/sub.
module accum_param
  import accum_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LIMIT = 2**WIDTH - 1,
  parameter int unsigned INIT  = 0
) (
  input  logic         clk,
  input  logic         rst,
  accum_param_if.slave bus
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_acc;
  logic             r_acc_vld;
  logic             r_ovf;
  logic             r_unf;
  logic             r_zero;

  logic [WIDTH-1:0] w_alu_sum;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [WIDTH-1:0] w_next_sum;

  accum_alu #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT),
    .INIT  (INIT)
  ) u_alu (
    .i_sum      (r_sum),
    .i_din      (bus.din),
    .i_mode     (bus.mode),
    .o_next_sum (w_alu_sum),
    .o_ovf_evt  (w_ovf_evt),
    .o_unf_evt  (w_unf_evt)
  );

  // Snapshot and zero flag both track the sum after this cycle's operation
  assign w_next_sum = bus.en ? w_alu_sum : r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum     <= INIT_W;
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_zero    <= (INIT_W == '0);
    end else begin
      r_sum     <= w_next_sum;
      r_zero    <= (w_next_sum == '0);
      r_acc_vld <= bus.show;
      if (bus.show) begin
        r_acc <= w_next_sum;
      end
      if (bus.en) begin
        if (bus.mode == MODE_CLR) begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end else begin
          if (w_ovf_evt) r_ovf <= 1'b1;
          if (w_unf_evt) r_unf <= 1'b1;
        end
      end
    end
  end

  assign bus.acc     = r_acc;
  assign bus.acc_vld = r_acc_vld;
  assign bus.ovf     = r_ovf;
  assign bus.unf     = r_unf;
  assign bus.zero    = r_zero;

endmodule

// File: tb/tb_accum_param.sv
module tb_accum_param;
  import accum_pkg::*;

  localparam int WIDTH = 6;
  localparam int LIMIT = 39;
  localparam int INIT  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  accum_param_if #(.WIDTH(WIDTH)) bus ();

  accum_param #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT),
    .INIT  (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference state
  int m_sum, m_acc, m_vld, m_ovf, m_unf, m_zero;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit e, input int md,
                                     input int d_raw, input bit s);
    int d, nxt;
    if (r) begin
      m_sum = INIT; m_acc = 0; m_vld = 0; m_ovf = 0; m_unf = 0;
      m_zero = (INIT == 0);
      return;
    end
    d   = (d_raw > LIMIT) ? LIMIT : d_raw;
    nxt = m_sum;
    if (e) begin
      case (md)
        0: begin
          if (m_sum + d > LIMIT) begin
            m_ovf = 1;
`ifdef ACCUM_SATURATE_EN
            nxt = LIMIT;
`else
            nxt = (m_sum + d) % (LIMIT + 1);
`endif
          end else nxt = m_sum + d;
        end
        1: begin
          if (d > m_sum) begin
            m_unf = 1;
`ifdef ACCUM_SATURATE_EN
            nxt = 0;
`else
            nxt = (m_sum - d + LIMIT + 1) % (LIMIT + 1);
`endif
          end else nxt = m_sum - d;
        end
        2: nxt = d;
        default: begin
          nxt = INIT; m_ovf = 0; m_unf = 0;
        end
      endcase
    end
    m_sum  = nxt;
    m_zero = (nxt == 0);
    if (s) m_acc = nxt;
    m_vld = s;
  endfunction

  task automatic cycle(input bit r, input bit e, input int md, input int d, input bit s);
    logic [WIDTH-1:0] dv;
    logic [1:0]       mv;
    dv = WIDTH'(d);
    mv = 2'(md);
    rst      = r;
    bus.en   = e;
    bus.mode = accum_mode_t'(mv);
    bus.din  = dv;
    bus.show = s;
    @(posedge clk);
    model_step(r, e, int'(mv), int'(dv), s);
    #1;
    chk("acc",     int'(bus.acc),     m_acc);
    chk("acc_vld", int'(bus.acc_vld), m_vld);
    chk("ovf",     int'(bus.ovf),     m_ovf);
    chk("unf",     int'(bus.unf),     m_unf);
    chk("zero",    int'(bus.zero),    m_zero);
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = MODE_ADD; bus.din = '0; bus.show = 1'b0;
    m_sum = 0; m_acc = 0; m_vld = 0; m_ovf = 0; m_unf = 0; m_zero = 1;

    // reset for two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_acc_const", int'(bus.acc), 0);
    chk("rst_zero_const", int'(bus.zero), 1);

    // add 5 x3 with show on third, then sub 20 wraps
    cycle(0, 1, 0, 5, 0);
    cycle(0, 1, 0, 5, 0);
    cycle(0, 1, 0, 5, 1);
    chk("add3_acc", int'(bus.acc), 15);
    cycle(0, 0, 0, 0, 0);
    chk("add3_vld_drop", int'(bus.acc_vld), 0);
    cycle(0, 1, 1, 20, 1);
    chk("sub_wrap_unf", int'(bus.unf), 1);

    // load 35, add 10 past LIMIT=39
    cycle(0, 1, 3, 0, 0);
    cycle(0, 1, 2, 35, 0);
    cycle(0, 1, 0, 10, 1);
`ifdef ACCUM_SATURATE_EN
    chk("add_ovf_sum", int'(bus.acc), 39);
`else
    chk("add_ovf_sum", int'(bus.acc), 5);
`endif
    chk("add_ovf_flag", int'(bus.ovf), 1);

    // load above LIMIT clamps; en=0 holds; show captures held sum
    cycle(0, 1, 2, 60, 0);
    cycle(0, 0, 0, 1, 1);
    chk("load_clamp_hold", int'(bus.acc), LIMIT);

    // clear with show in same cycle after overflow
    cycle(0, 1, 0, 39, 0);
    cycle(0, 1, 3, 0, 1);
    chk("clr_ovf", int'(bus.ovf), 0);
    chk("clr_acc", int'(bus.acc), 0);

    // show held 4 cycles while adding 1; then reset in the middle
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 1);
    chk("show_run_acc", int'(bus.acc), 4);
    cycle(0, 1, 3, 0, 0);
    cycle(0, 1, 0, 1, 1);
    cycle(0, 1, 0, 1, 1);
    cycle(1, 1, 0, 1, 1);
    chk("rst_mid_acc", int'(bus.acc), 0);
    chk("rst_mid_vld", int'(bus.acc_vld), 0);

    // randomized run
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 63)),
            $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
